// File: rtl/timer_writeback_arbiter.sv
// Round-robin merge of the command-timer completion channels into one
// register-file writeback port, with a single-entry output register.
module timer_writeback_arbiter #(
    parameter int DATABITWIDTH = 16,
    parameter int CHANNELS     = 8
) (
    input  logic                        clk,
    input  logic                        clk_en,
    input  logic                        sync_rst,
    input  logic [CHANNELS-1:0]         TimerInACK,
    output logic [CHANNELS-1:0]         TimerInREQ,
    input  logic [CHANNELS*4-1:0]       RegisterDestIn,
    input  logic [CHANNELS*32-1:0]      TimerDataIn,
    output logic                        WritebackACK,
    input  logic                        WritebackREQ,
    output logic [3:0]                  WritebackDest,
    output logic [DATABITWIDTH-1:0]     WritebackData,
    output logic [$clog2(CHANNELS)-1:0] WritebackSource
);

    localparam int SW = $clog2(CHANNELS);

    logic                    out_valid;
    logic [3:0]              out_dest;
    logic [DATABITWIDTH-1:0] out_data;
    logic [SW-1:0]           out_source;
    logic [SW-1:0]           last_grant;

    logic                    grant_valid;
    logic [SW-1:0]           grant_idx;
    logic [SW-1:0]           scan_idx;
    logic                    out_free;
    logic                    accept;
    logic                    drain;
    logic [3:0]              sel_dest;
    logic [31:0]             sel_data;
    logic [DATABITWIDTH-1:0] fit_data;

    // Scan starts one past the last winner; SW-bit wrap gives the modulo
    // because CHANNELS is a power of two. The last probe revisits last_grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            scan_idx = last_grant + SW'(k);
            if (!grant_valid && TimerInACK[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign out_free = ~out_valid | WritebackREQ;
    assign accept   = clk_en & ~sync_rst & out_free & grant_valid;
    assign drain    = clk_en & out_valid & WritebackREQ;

    always_comb begin
        TimerInREQ = '0;
        if (accept) begin
            TimerInREQ[grant_idx] = 1'b1;
        end
    end

    assign sel_dest = RegisterDestIn[4*int'(grant_idx) +: 4];
    assign sel_data = TimerDataIn[32*int'(grant_idx) +: 32];

    generate
        if (DATABITWIDTH < 32) begin : g_trunc
            logic unused_data_hi;
            assign unused_data_hi = ^sel_data[31:DATABITWIDTH];
            assign fit_data = sel_data[DATABITWIDTH-1:0];
        end else if (DATABITWIDTH == 32) begin : g_exact
            assign fit_data = sel_data;
        end else begin : g_zext
            assign fit_data = {{(DATABITWIDTH-32){1'b0}}, sel_data};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            out_valid  <= 1'b0;
            out_dest   <= '0;
            out_data   <= '0;
            out_source <= '0;
            last_grant <= SW'(CHANNELS - 1);
        end else if (clk_en) begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_dest   <= sel_dest;
                out_data   <= fit_data;
                out_source <= grant_idx;
                last_grant <= grant_idx;
            end else if (drain) begin
                out_valid  <= 1'b0;
            end
        end
    end

    assign WritebackACK    = out_valid;
    assign WritebackDest   = out_dest;
    assign WritebackData   = out_data;
    assign WritebackSource = out_source;

endmodule

// File: tb/tb_timer_writeback_arbiter.sv
// Self-checking bench for timer_writeback_arbiter: scenario tasks plus a
// scoreboard that matches every accepted input against its writeback.
module tb_timer_writeback_arbiter;

    localparam int CH = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          clk_en;
    logic          sync_rst;
    logic [CH-1:0] ack;
    logic [CH-1:0] TimerInREQ;
    logic [CH*4-1:0]  dest_flat;
    logic [CH*32-1:0] data_flat;
    logic          WritebackACK;
    logic          wb_req;
    logic [3:0]    WritebackDest;
    logic [DW-1:0] WritebackData;
    logic [2:0]    WritebackSource;

    logic [3:0]  dest_tbl [CH];
    logic [31:0] data_tbl [CH];

    typedef struct packed {
        logic [3:0]    dest;
        logic [DW-1:0] data;
        logic [2:0]    src;
    } entry_t;
    entry_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int wb_count = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            dest_flat[4*i +: 4]   = dest_tbl[i];
            data_flat[32*i +: 32] = data_tbl[i];
        end
    end

    timer_writeback_arbiter #(.DATABITWIDTH(DW), .CHANNELS(CH)) dut (
        .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
        .TimerInACK(ack), .TimerInREQ(TimerInREQ),
        .RegisterDestIn(dest_flat), .TimerDataIn(data_flat),
        .WritebackACK(WritebackACK), .WritebackREQ(wb_req),
        .WritebackDest(WritebackDest), .WritebackData(WritebackData),
        .WritebackSource(WritebackSource)
    );

    // Scoreboard: pop/compare on writeback transfer, push on input transfer.
    always @(negedge clk) begin
        if (sync_rst) begin
            sb.delete();
        end else if (clk_en) begin
            if (WritebackACK && wb_req) begin
                entry_t e;
                wb_count++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got src=%0d dest=%0d data=%h, expected none",
                             WritebackSource, WritebackDest, WritebackData);
                end else begin
                    e = sb.pop_front();
                    if ({WritebackDest, WritebackData, WritebackSource} !== e) begin
                        n_fail++;
                        $display("FAIL sb_entry: got src=%0d dest=%0d data=%h, expected src=%0d dest=%0d data=%h",
                                 WritebackSource, WritebackDest, WritebackData, e.src, e.dest, e.data);
                    end
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (ack[i] && TimerInREQ[i]) begin
                    sb.push_back({dest_tbl[i], data_tbl[i][DW-1:0], 3'(i)});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        sync_rst = 1'b1;
        ack      = '0;
        wb_req   = 1'b0;
        clk_en   = 1'b1;
        step();
        step();
        sync_rst = 1'b0;
    endtask

    task automatic test_reset();
        sync_rst = 1'b1;
        clk_en   = 1'b1;
        wb_req   = 1'b1;
        ack      = '1;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if (TimerInREQ !== '0) begin
            n_fail++;
            $display("FAIL reset_req: got %b, expected 0", TimerInREQ);
        end
        n_checks++;
        if ({WritebackACK, WritebackDest, WritebackData, WritebackSource} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got ack=%b dest=%0d data=%h src=%0d, expected all 0",
                     WritebackACK, WritebackDest, WritebackData, WritebackSource);
        end
        step();
        sync_rst = 1'b0;
        ack      = '0;
    endtask

    task automatic test_single();
        dest_tbl[3] = 4'd5;
        data_tbl[3] = 32'h0001_ABCD;
        wb_req = 1'b1;
        ack    = 8'h08;
        @(negedge clk);
        n_checks++;
        if (TimerInREQ !== 8'h08) begin
            n_fail++;
            $display("FAIL single_req: got %b, expected 00001000", TimerInREQ);
        end
        step();
        ack = '0;
        @(negedge clk);
        n_checks++;
        if (WritebackACK !== 1'b1 || WritebackDest !== 4'd5 || WritebackData !== 16'hABCD ||
            WritebackSource !== 3'd3) begin
            n_fail++;
            $display("FAIL single_out: got ack=%b dest=%0d data=%h src=%0d, expected 1 5 abcd 3",
                     WritebackACK, WritebackDest, WritebackData, WritebackSource);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (WritebackACK !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got ack=%b, expected 0", WritebackACK);
        end
        step();
    endtask

    task automatic test_round_robin();
        apply_reset();
        ack    = '1;
        wb_req = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_checks++;
            if (TimerInREQ !== 8'(1 << (c % 8))) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b, expected channel %0d", c, TimerInREQ, c % 8);
            end
            if (c > 0) begin
                n_checks++;
                if (WritebackACK !== 1'b1 || WritebackSource !== 3'((c - 1) % 8)) begin
                    n_fail++;
                    $display("FAIL rr_out[%0d]: got ack=%b src=%0d, expected 1 %0d",
                             c, WritebackACK, WritebackSource, (c - 1) % 8);
                end
            end
            step();
        end
        ack = '0;
        step();
        step();
    endtask

    task automatic test_stall();
        logic [3:0]    held_dest;
        logic [DW-1:0] held_data;
        apply_reset();
        ack    = 8'h44;
        wb_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (TimerInREQ !== 8'h04) begin
            n_fail++;
            $display("FAIL stall_first: got %b, expected 00000100", TimerInREQ);
        end
        held_dest = dest_tbl[2];
        held_data = data_tbl[2][DW-1:0];
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (TimerInREQ !== '0 || WritebackACK !== 1'b1 || WritebackSource !== 3'd2 ||
                WritebackDest !== held_dest || WritebackData !== held_data) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got req=%b ack=%b src=%0d dest=%0d data=%h, expected 0 1 2 %0d %h",
                         c, TimerInREQ, WritebackACK, WritebackSource, WritebackDest, WritebackData,
                         held_dest, held_data);
            end
            step();
        end
        wb_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (TimerInREQ !== 8'h40) begin
            n_fail++;
            $display("FAIL stall_release: got %b, expected 01000000", TimerInREQ);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (WritebackSource !== 3'd6 || TimerInREQ !== 8'h04) begin
            n_fail++;
            $display("FAIL stall_next: got src=%0d req=%b, expected 6 00000100", WritebackSource, TimerInREQ);
        end
        step();
        ack = '0;
        @(negedge clk);
        n_checks++;
        if (WritebackSource !== 3'd2 || WritebackACK !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_last: got src=%0d ack=%b, expected 2 1", WritebackSource, WritebackACK);
        end
        step();
        step();
    endtask

    task automatic test_back_pressure();
        int order [4] = '{1, 2, 3, 4};
        int n_acc = 0;
        int start_count;
        logic [CH-1:0] next_ack;
        apply_reset();
        start_count = wb_count;
        ack = 8'h1E;
        for (int k = 0; k < 30 && (wb_count - start_count) < 4; k++) begin
            wb_req = (k % 2 == 0);
            @(negedge clk);
            next_ack = ack;
            if ((TimerInREQ & ack) != '0) begin
                n_checks++;
                if (n_acc >= 4 || TimerInREQ !== 8'(1 << order[n_acc])) begin
                    n_fail++;
                    $display("FAIL bp_grant[%0d]: got %b, expected channel %0d",
                             n_acc, TimerInREQ, (n_acc < 4) ? order[n_acc] : -1);
                end
                next_ack = ack & ~TimerInREQ;
                n_acc++;
            end
            step();
            ack = next_ack;
        end
        wb_req = 1'b1;
        step();
        step();
        n_checks++;
        if ((wb_count - start_count) != 4 || n_acc != 4 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got writebacks=%0d accepts=%0d pending=%0d, expected 4 4 0",
                     wb_count - start_count, n_acc, sb.size());
        end
    endtask

    task automatic test_clk_en();
        apply_reset();
        ack    = 8'h02;
        wb_req = 1'b0;
        step();
        ack    = 8'h01;
        clk_en = 1'b0;
        wb_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (TimerInREQ !== '0 || WritebackACK !== 1'b1 || WritebackSource !== 3'd1) begin
                n_fail++;
                $display("FAIL clken_hold[%0d]: got req=%b ack=%b src=%0d, expected 0 1 1",
                         c, TimerInREQ, WritebackACK, WritebackSource);
            end
            step();
        end
        clk_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (TimerInREQ !== 8'h01) begin
            n_fail++;
            $display("FAIL clken_resume: got %b, expected 00000001", TimerInREQ);
        end
        step();
        ack = '0;
        @(negedge clk);
        n_checks++;
        if (WritebackSource !== 3'd0 || WritebackACK !== 1'b1) begin
            n_fail++;
            $display("FAIL clken_out: got src=%0d ack=%b, expected 0 1", WritebackSource, WritebackACK);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        ack    = 8'h20;
        wb_req = 1'b0;
        step();
        ack = '0;
        @(negedge clk);
        n_checks++;
        if (WritebackACK !== 1'b1 || WritebackSource !== 3'd5) begin
            n_fail++;
            $display("FAIL rstmid_load: got ack=%b src=%0d, expected 1 5", WritebackACK, WritebackSource);
        end
        step();
        sync_rst = 1'b1;
        ack      = 8'h50;
        @(negedge clk);
        n_checks++;
        if (TimerInREQ !== '0) begin
            n_fail++;
            $display("FAIL rstmid_req: got %b, expected 0", TimerInREQ);
        end
        step();
        sync_rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (WritebackACK !== 1'b0 || TimerInREQ !== 8'h10) begin
            n_fail++;
            $display("FAIL rstmid_after: got ack=%b req=%b, expected 0 00010000", WritebackACK, TimerInREQ);
        end
        wb_req = 1'b1;
        step();
        ack = '0;
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            dest_tbl[i] = 4'(i + 9);
            data_tbl[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_1111 + 32'h0000_0007;
        end
        clk_en   = 1'b1;
        sync_rst = 1'b1;
        ack      = '0;
        wb_req   = 1'b0;

        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_back_pressure();
        test_clk_en();
        test_reset_mid();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
